// File: rtl/bombe_crib_search.sv
// bombe_crib_search
//   Two-rotor crib search engine. A crib of CRIB_LEN (ciphertext, plaintext)
//   ASCII pairs is loaded first. The engine then tries one key per clock over
//   the (start offset, per-letter step) space. Letter i decrypts with shift
//   (start + i*step) mod ALPHA. A key is a hit when every position decrypts
//   to its plaintext letter.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   char_in, plain_in     crib pair presented for the current load slot
//   load_valid/load_ready load handshake (see below)
//   go                    start a search (READY or DONE)
//   next                  resume after a hit (HIT only)
//   abort                 stop the search (SEARCH or HIT) -> DONE
//   clear                 discard the crib and results -> LOAD
//   busy, found, done     status flags
//   key_start, key_step   current or last hit key; all ones if there is none
//   hit_count             hits found since the last go
//   state_out             raw state encoding for debug and HEX display
//
// Handshake: a crib pair transfers on any rising edge where load_valid and
// load_ready are both high and clear is low. load_ready depends only on the
// state, never on load_valid. The source may change char_in and plain_in
// freely between transfers.
module bombe_crib_search #(
  parameter int          CRIB_LEN = 3,
  parameter int          ALPHA    = 26,
  parameter logic [7:0]  BASE     = 8'd65,
  localparam int         KW       = $clog2(ALPHA),
  localparam int         CW       = $clog2(ALPHA*ALPHA+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    char_in,
  input  logic [7:0]    plain_in,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic          go,
  input  logic          next,
  input  logic          abort,
  input  logic          clear,
  output logic          busy,
  output logic          found,
  output logic          done,
  output logic [KW-1:0] key_start,
  output logic [KW-1:0] key_step,
  output logic [CW-1:0] hit_count,
  output logic [2:0]    state_out
);

  localparam int IW = (CRIB_LEN > 1) ? $clog2(CRIB_LEN) : 1;
  localparam logic [KW:0]   ALPHA_W   = (KW+1)'(ALPHA);
  localparam logic [9:0]    ALPHA_10  = 10'(ALPHA);
  localparam logic [KW-1:0] LAST_KEY  = KW'(ALPHA-1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(ALPHA*ALPHA);
  localparam logic [IW-1:0] LAST_SLOT = IW'(CRIB_LEN-1);

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_READY  = 3'd1,
    S_SEARCH = 3'd2,
    S_HIT    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   idx;
  logic [7:0]      crib_c [CRIB_LEN];
  logic [7:0]      crib_p [CRIB_LEN];
  logic [KW-1:0]   cur_start;
  logic [KW-1:0]   cur_step;

  // control strobes produced by the FSM, consumed by the datapath
  logic            do_clear;
  logic            do_store;
  logic            do_go;
  logic            do_hit;
  logic            do_advance;

  logic [CRIB_LEN-1:0] pos_match;
  logic            key_match;
  logic            last_key;

  // Per-position match. acc carries (start + i*step) mod ALPHA from one
  // position to the next; both operands stay below ALPHA, so one
  // conditional subtraction in KW+1 bits keeps it reduced without overflow.
  logic [KW:0] acc;
  logic [9:0]  lo, hi, cx, px, cv, pv, shift, d;

  always_comb begin
    acc       = {1'b0, cur_start};
    lo        = {2'b00, BASE};
    hi        = lo + ALPHA_10;
    cx        = '0;
    px        = '0;
    cv        = '0;
    pv        = '0;
    shift     = '0;
    d         = '0;
    pos_match = '0;
    for (int i = 0; i < CRIB_LEN; i++) begin
      if (i > 0) begin
        acc = acc + {1'b0, cur_step};
        if (acc >= ALPHA_W) acc = acc - ALPHA_W;
      end
      cx    = {2'b00, crib_c[i]};
      px    = {2'b00, crib_p[i]};
      cv    = cx - lo;
      pv    = px - lo;
      shift = 10'(acc);
      // wrap the letter back into 0..ALPHA-1 on borrow
      if (cv < shift) d = cv + ALPHA_10 - shift;
      else            d = cv - shift;
      // out-of-alphabet letters can never match
      pos_match[i] = (cx >= lo) && (cx < hi) && (px >= lo) && (px < hi) && (d == pv);
    end
  end

  assign key_match = &pos_match;
  assign last_key  = (cur_start == LAST_KEY) && (cur_step == LAST_KEY);

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_LOAD;
    else        state <= state_next;
  end

  // next state and strobes; clear beats abort beats go/next/load
  always_comb begin
    state_next = state;
    do_clear   = 1'b0;
    do_store   = 1'b0;
    do_go      = 1'b0;
    do_hit     = 1'b0;
    do_advance = 1'b0;
    if (clear) begin
      do_clear   = 1'b1;
      state_next = S_LOAD;
    end else begin
      case (state)
        S_LOAD: begin
          if (load_valid) begin
            do_store = 1'b1;
            if (idx == LAST_SLOT) state_next = S_READY;
          end
        end
        S_READY, S_DONE: begin
          if (go) begin
            do_go      = 1'b1;
            state_next = S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (abort) begin
            state_next = S_DONE;
          end else if (key_match) begin
            do_hit     = 1'b1;
            state_next = S_HIT;
          end else if (last_key) begin
            state_next = S_DONE;
          end else begin
            do_advance = 1'b1;
          end
        end
        S_HIT: begin
          if (abort) begin
            state_next = S_DONE;
          end else if (next) begin
            if (last_key) begin
              state_next = S_DONE;
            end else begin
              do_advance = 1'b1;
              state_next = S_SEARCH;
            end
          end
        end
        default: state_next = S_LOAD;
      endcase
    end
  end

  // datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      cur_start <= '0;
      cur_step  <= '0;
      hit_count <= '0;
      key_start <= '1;
      key_step  <= '1;
      for (int i = 0; i < CRIB_LEN; i++) begin
        crib_c[i] <= '0;
        crib_p[i] <= '0;
      end
    end else if (do_clear) begin
      idx       <= '0;
      cur_start <= '0;
      cur_step  <= '0;
      hit_count <= '0;
      key_start <= '1;
      key_step  <= '1;
      for (int i = 0; i < CRIB_LEN; i++) begin
        crib_c[i] <= '0;
        crib_p[i] <= '0;
      end
    end else begin
      if (do_store) begin
        for (int i = 0; i < CRIB_LEN; i++) begin
          if (idx == IW'(i)) begin
            crib_c[i] <= char_in;
            crib_p[i] <= plain_in;
          end
        end
        if (idx == LAST_SLOT) idx <= '0;
        else                  idx <= idx + IW'(1);
      end
      if (do_go) begin
        cur_start <= '0;
        cur_step  <= '0;
        hit_count <= '0;
        key_start <= '1;
        key_step  <= '1;
      end
      if (do_hit) begin
        key_start <= cur_start;
        key_step  <= cur_step;
        if (hit_count != COUNT_MAX) hit_count <= hit_count + CW'(1);
      end
      // start is the inner rotor; it carries into step
      if (do_advance) begin
        if (cur_start == LAST_KEY) begin
          cur_start <= '0;
          cur_step  <= cur_step + KW'(1);
        end else begin
          cur_start <= cur_start + KW'(1);
        end
      end
    end
  end

  assign load_ready = (state == S_LOAD);
  assign busy       = (state == S_SEARCH);
  assign done       = (state == S_DONE);
  assign found      = (state == S_HIT) || ((state == S_DONE) && (hit_count != '0));
  assign state_out  = state;

endmodule

// File: tb/tb_bombe_crib_search.sv
// Bench for bombe_crib_search. Instance u0 uses a 3-letter crib; instance
// u1 uses a 1-letter crib. A reference model enumerates the key space
// directly from the decrypt rule and lists the expected hit keys; a monitor
// checks u0 against that list every cycle. Directed tests add literal
// expectations.
module tb_bombe_crib_search;

  localparam int ALPHA = 26;
  localparam int NKEYS = ALPHA * ALPHA;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // u0 signals
  logic [7:0] c0, p0;
  logic       lv0, lr0, go0, nx0, ab0, cl0, busy0, found0, done0;
  logic [4:0] ks0, kp0;
  logic [9:0] hc0;
  logic [2:0] st0;
  // u1 signals
  logic [7:0] c1, p1;
  logic       lv1, lr1, go1, nx1, ab1, cl1, busy1, found1, done1;
  logic [4:0] ks1, kp1;
  logic [9:0] hc1;
  logic [2:0] st1;

  bombe_crib_search #(.CRIB_LEN(3)) u0 (
    .clk(clk), .reset(reset), .char_in(c0), .plain_in(p0),
    .load_valid(lv0), .load_ready(lr0), .go(go0), .next(nx0), .abort(ab0),
    .clear(cl0), .busy(busy0), .found(found0), .done(done0),
    .key_start(ks0), .key_step(kp0), .hit_count(hc0), .state_out(st0)
  );

  bombe_crib_search #(.CRIB_LEN(1)) u1 (
    .clk(clk), .reset(reset), .char_in(c1), .plain_in(p1),
    .load_valid(lv1), .load_ready(lr1), .go(go1), .next(nx1), .abort(ab1),
    .clear(cl1), .busy(busy1), .found(found1), .done(done1),
    .key_start(ks1), .key_step(kp1), .hit_count(hc1), .state_out(st1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // crib for u0, written only by the driver
  logic [7:0] m_c [3];
  logic [7:0] m_p [3];
  bit         abort_exp = 0;

  // expected hit key indices n = step*ALPHA + start, in search order
  logic [9:0] exp_q [$];

  function automatic void build_model();
    int c, p, s, st, sp;
    bit ok;
    exp_q.delete();
    for (int n = 0; n < NKEYS; n++) begin
      st = n % ALPHA;
      sp = n / ALPHA;
      ok = 1;
      for (int i = 0; i < 3; i++) begin
        c = int'(m_c[i]) - 65;
        p = int'(m_p[i]) - 65;
        s = st + i * sp;
        if (c < 0 || c >= ALPHA || p < 0 || p >= ALPHA) ok = 0;
        else if ((((c - s) % ALPHA) + ALPHA) % ALPHA != p) ok = 0;
      end
      if (ok) exp_q.push_back(10'(n));
    end
  endfunction

  // ---------------- monitor for u0 ----------------
  logic [2:0] prev_st = 3'd0;
  int         busy_cnt = 0;
  int         hits_seen = 0;
  int         last_n = 0;
  int         n_exp;

  always @(negedge clk) begin
    if (!reset) begin
      prev_st   = 3'd0;
      busy_cnt  = 0;
      hits_seen = 0;
      exp_q.delete();
    end else begin
      if (st0 == 3'd2 && (prev_st == 3'd1 || prev_st == 3'd4)) begin
        build_model();
        busy_cnt  = 0;
        hits_seen = 0;
      end
      if (st0 == 3'd0) begin
        exp_q.delete();
        busy_cnt  = 0;
        hits_seen = 0;
      end
      check("mon_load_ready", lr0, st0 == 3'd0);
      check("mon_busy", busy0, st0 == 3'd2);
      check("mon_done", done0, st0 == 3'd4);
      if (busy0) busy_cnt++;
      if (st0 == 3'd3 && prev_st != 3'd3) begin
        n_exp = (exp_q.size() != 0) ? int'(exp_q.pop_front()) : 1023;
        check("mon_hit_start", 32'(ks0), n_exp % ALPHA);
        check("mon_hit_step", 32'(kp0), n_exp / ALPHA);
        check("mon_hit_count", 32'(hc0), hits_seen + 1);
        check("mon_hit_latency", busy_cnt, n_exp + 1);
        hits_seen++;
        last_n = n_exp;
      end
      if (st0 == 3'd3) check("mon_found_hit", found0, 1);
      if (st0 == 3'd4) begin
        check("mon_found_done", found0, hits_seen != 0);
        if (prev_st != 3'd4) begin
          check("mon_done_count", 32'(hc0), hits_seen);
          check("mon_done_start", 32'(ks0), (hits_seen != 0) ? last_n % ALPHA : 32'h1F);
          check("mon_done_step", 32'(kp0), (hits_seen != 0) ? last_n / ALPHA : 32'h1F);
          if (!abort_exp) begin
            check("mon_hits_left", exp_q.size(), 0);
            check("mon_search_cycles", busy_cnt, NKEYS);
          end
        end
      end
      prev_st = st0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load0(input logic [23:0] cs, input logic [23:0] ps);
    for (int i = 0; i < 3; i++) begin
      m_c[i] = cs[23-8*i -: 8];
      m_p[i] = ps[23-8*i -: 8];
    end
    for (int i = 0; i < 3; i++) begin
      c0  = m_c[i];
      p0  = m_p[i];
      lv0 = 1'b1;
      tick();
    end
    lv0 = 1'b0;
    check("load_to_ready", st0, 3'd1);
  endtask

  task automatic pulse_go0();   go0 = 1'b1; tick(); go0 = 1'b0; endtask
  task automatic pulse_next0(); nx0 = 1'b1; tick(); nx0 = 1'b0; endtask
  task automatic pulse_clear0(); cl0 = 1'b1; tick(); cl0 = 1'b0; endtask

  // wait until the selected instance is in HIT or DONE
  task automatic wait_stop(input int which, output bit to);
    bit stopped;
    stopped = 0;
    for (int k = 0; k < 2000 && !stopped; k++) begin
      stopped = (which == 0) ? (st0 == 3'd3 || st0 == 3'd4) : (st1 == 3'd3 || st1 == 3'd4);
      if (!stopped) tick();
    end
    to = !stopped;
    if (to) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout dut=%0d state0=%0d state1=%0d", which, st0, st1);
    end
  endtask

  task automatic run_all0();
    bit to;
    pulse_go0();
    for (int h = 0; h < 800 && st0 != 3'd4; h++) begin
      wait_stop(0, to);
      if (to) break;
      if (st0 == 3'd3) pulse_next0();
    end
    check("run_all_done", st0, 3'd4);
  endtask

  task automatic check_reset0(input string tag);
    check({tag, "_state"}, st0, 3'd0);
    check({tag, "_load_ready"}, lr0, 1);
    check({tag, "_busy"}, busy0, 0);
    check({tag, "_found"}, found0, 0);
    check({tag, "_done"}, done0, 0);
    check({tag, "_key_start"}, ks0, 5'h1F);
    check({tag, "_key_step"}, kp0, 5'h1F);
    check({tag, "_hit_count"}, hc0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit to;
    reset = 1'b0;
    {c0, p0, lv0, go0, nx0, ab0, cl0} = '0;
    {c1, p1, lv1, go1, nx1, ab1, cl1} = '0;
    tick(); tick();
    check_reset0("reset");
    check("reset_u1_state", st1, 3'd0);
    check("reset_u1_key_start", ks1, 5'h1F);
    check("reset_u1_hit_count", hc1, 0);
    reset = 1'b1;
    tick();

    // Test 1: single hit at key (2,1), index 28, then exhaust
    load0("CEG", "ABC");
    pulse_go0();
    wait_stop(0, to);
    check("t1_hit_state", st0, 3'd3);
    check("t1_key_start", ks0, 5'd2);
    check("t1_key_step", kp0, 5'd1);
    check("t1_hit_count", hc0, 10'd1);
    check("t1_found", found0, 1);
    pulse_next0();
    wait_stop(0, to);
    check("t1_done_state", st0, 3'd4);
    check("t1_done_found", found0, 1);
    check("t1_done_count", hc0, 10'd1);

    // Test 2: letter wrap path, single hit at (1,1)
    pulse_clear0();
    check("t2_clear_ready", lr0, 1);
    load0("YAC", "XYZ");
    run_all0();
    check("t2_key_start", ks0, 5'd1);
    check("t2_key_step", kp0, 5'd1);
    check("t2_hit_count", hc0, 10'd1);

    // Test 3: non-letter in crib -> no hit anywhere
    pulse_clear0();
    load0("CE#", "ABC");
    pulse_go0();
    wait_stop(0, to);
    check("t3_state", st0, 3'd4);
    check("t3_found", found0, 0);
    check("t3_hit_count", hc0, 10'd0);
    check("t3_key_start", ks0, 5'h1F);
    check("t3_key_step", kp0, 5'h1F);

    // Test 5: clear beats go mid-search; abort in HIT keeps the count
    pulse_clear0();
    load0("CEG", "ABC");
    pulse_go0();
    repeat (5) tick();
    cl0 = 1'b1;
    go0 = 1'b1;
    tick();
    cl0 = 1'b0;
    go0 = 1'b0;
    check("t5_clear_state", st0, 3'd0);
    check("t5_clear_ready", lr0, 1);
    check("t5_clear_count", hc0, 10'd0);
    load0("CEG", "ABC");
    pulse_go0();
    wait_stop(0, to);
    check("t5_hit_state", st0, 3'd3);
    abort_exp = 1;
    ab0 = 1'b1;
    tick();
    ab0 = 1'b0;
    check("t5_abort_state", st0, 3'd4);
    check("t5_abort_count", hc0, 10'd1);
    check("t5_abort_found", found0, 1);
    tick();
    abort_exp = 0;
    // go from DONE restarts the search with the same crib
    run_all0();
    check("t5_rerun_count", hc0, 10'd1);
    check("t5_rerun_start", ks0, 5'd2);

    // Test 4: one-letter crib, 26 hits at start 3, every step
    c1  = "D";
    p1  = "A";
    lv1 = 1'b1;
    tick();
    lv1 = 1'b0;
    check("t4_ready", st1, 3'd1);
    go1 = 1'b1;
    tick();
    go1 = 1'b0;
    for (int h = 0; h < ALPHA; h++) begin
      wait_stop(1, to);
      if (to) break;
      check("t4_hit_state", st1, 3'd3);
      check("t4_key_start", ks1, 5'd3);
      check("t4_key_step", 32'(kp1), h);
      check("t4_hit_count", 32'(hc1), h + 1);
      nx1 = 1'b1;
      tick();
      nx1 = 1'b0;
    end
    wait_stop(1, to);
    check("t4_done_state", st1, 3'd4);
    check("t4_final_count", hc1, 10'd26);
    check("t4_done_found", found1, 1);

    // Test 6: asynchronous reset mid-search, then rerun test 1
    pulse_go0();
    repeat (10) tick();
    check("t6_busy_before", busy0, 1);
    reset = 1'b0;
    #2;
    check_reset0("t6_async");
    tick();
    reset = 1'b1;
    tick();
    load0("CEG", "ABC");
    run_all0();
    check("t6_key_start", ks0, 5'd2);
    check("t6_key_step", kp0, 5'd1);
    check("t6_hit_count", hc0, 10'd1);
    check("t6_found", found0, 1);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
